// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data memory controller.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (0 for illegal).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for a little-endian 32-bit memory word:
// store mask and data placement, alignment check, and load extraction.
module dm_lane_align (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        load_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic        misalign,
  output logic [31:0] rdata_ext
);
  import dm_pkg::*;

  logic [4:0]  lane_shift;
  logic [31:0] shifted;

  assign lane_shift = {addr_lo, 3'b000};
  assign shifted    = rdata_word >> lane_shift;

  // Place store data into its byte lanes and flag misaligned halves/words.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'd0;
    misalign   = 1'b0;
    case (size)
      SZ_BYTE: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {24'd0, wdata[7:0]} << lane_shift;
      end
      SZ_HALF: begin
        misalign   = addr_lo[0];
        byte_en    = 4'b0011 << addr_lo;
        wdata_lane = {16'd0, wdata[15:0]} << lane_shift;
      end
      SZ_WORD: begin
        misalign   = (addr_lo != 2'b00);
        byte_en    = 4'b1111;
        wdata_lane = wdata;
      end
      default: begin
        byte_en    = 4'b0000;
      end
    endcase
  end

  // Pull the addressed bytes down to bit 0 and sign- or zero-extend them.
  always_comb begin
    rdata_ext = 32'd0;
    case (size)
      SZ_BYTE: rdata_ext = load_unsigned ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = load_unsigned ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata_ext = shifted;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory with valid/ready request and
// response channels and configurable wait states. The WAIT state always
// lasts WAIT_CYCLES+1 cycles; its final edge is the commit edge, so a
// response appears WAIT_CYCLES+1 edges after the request is accepted.
module data_mem_ctrl #(
  parameter int DEPTH_BYTES = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import dm_pkg::*;

  localparam int AW = $clog2(DEPTH_BYTES);

  state_t      state;
  logic        started;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [AW-3:0] word_idx;
  logic [31:0]   rd_word;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lane;
  logic          misalign;
  logic [31:0]   rdata_ext;
  logic [32:0]   last_addr;
  logic          out_of_range;
  logic          access_err;
  logic          commit;

  // req_ready is held low until the first edge after reset release.
  assign req_ready = started && (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign commit    = (state == WAIT) && (wait_cnt == 4'(WAIT_CYCLES));

  assign word_idx = addr_q[AW-1:2];
  assign rd_word  = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                     mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};

  // The 33-bit sum catches both high address bits and wrap past 2^32.
  assign last_addr    = {1'b0, addr_q} + {30'd0, size_bytes(size_q)} - 33'd1;
  assign out_of_range = (last_addr >= 33'(DEPTH_BYTES));
  assign access_err   = (size_q == SZ_ILLEGAL) || misalign || out_of_range;

  dm_lane_align u_lane (
    .size          (size_q),
    .addr_lo       (addr_q[1:0]),
    .load_unsigned (uns_q),
    .wdata         (wdata_q),
    .rdata_word    (rd_word),
    .byte_en       (byte_en),
    .wdata_lane    (wdata_lane),
    .misalign      (misalign),
    .rdata_ext     (rdata_ext)
  );

  // Request latch, wait counter, response registers and IDLE/WAIT/RESP sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      started   <= 1'b0;
      wait_cnt  <= 4'd0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      uns_q     <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= 4'd0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (commit) begin
            rsp_err   <= access_err;
            rsp_rdata <= (we_q || access_err) ? 32'd0 : rdata_ext;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte-masked store on the commit edge; erroneous accesses never write.
  always_ff @(posedge clk) begin
    if (commit && we_q && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[{word_idx, 2'(i)}] <= wdata_lane[8*i +: 8];
        end
      end
    end
  end

endmodule
